// File: rtl/term_pkg.sv
// ============================================================================
// Module      : term_pkg
// Description : Shared terminal definitions: ASCII codes, decoder states and
//               default screen geometry. Also used by termbuffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package term_pkg;

    localparam int COLS_DEF = 80;
    localparam int ROWS_DEF = 24;

    localparam logic [7:0] c_esc    = 8'h1B;
    localparam logic [7:0] c_cr     = 8'h0D;
    localparam logic [7:0] c_lf     = 8'h0A;
    localparam logic [7:0] c_bs     = 8'h08;
    localparam logic [7:0] c_sp     = 8'h20;
    localparam logic [7:0] c_lbrack = 8'h5B;
    localparam logic [7:0] c_semi   = 8'h3B;

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_ESC    = 2'd1,
        ST_CSI    = 2'd2,
        ST_SWEEP  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/vt_param_acc.sv
// ============================================================================
// Module      : vt_param_acc
// Description : Two 8-bit saturating decimal accumulators for CSI parameters,
//               selected by an index that a separator advances once.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vt_param_acc (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       dig_v,
    input  logic [3:0] dig,
    input  logic       sep,
    output logic [7:0] p0,
    output logic [7:0] p1
);

    logic       r_idx;
    logic [7:0] r_p0;
    logic [7:0] r_p1;
    logic [7:0] w_cur;
    logic [11:0] w_prod;
    logic [7:0] w_sat;

    // Next value of the selected parameter: P*10+d, clipped at 255
    always_comb begin
        w_cur  = r_idx ? r_p1 : r_p0;
        w_prod = ({4'b0, w_cur} * 12'd10) + {8'b0, dig};
        w_sat  = (w_prod > 12'd255) ? 8'd255 : w_prod[7:0];
    end

    // Parameter registers; a second separator leaves the index on P1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= 1'b0;
            r_p0  <= 8'd0;
            r_p1  <= 8'd0;
        end else if (clr) begin
            r_idx <= 1'b0;
            r_p0  <= 8'd0;
            r_p1  <= 8'd0;
        end else if (dig_v) begin
            if (r_idx) r_p1 <= w_sat;
            else       r_p0 <= w_sat;
        end else if (sep) begin
            r_idx <= 1'b1;
        end
    end

    assign p0 = r_p0;
    assign p1 = r_p1;

endmodule

`default_nettype wire

// File: rtl/vt_decoder.sv
// ============================================================================
// Module      : vt_decoder
// Description : Terminal byte-stream decoder: printable ASCII, CR/LF/BS and a
//               VT100 CSI subset (H/f, A-D, 2J, K) driving a character-cell
//               write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vt_decoder
    import term_pkg::*;
#(
    parameter int COLS = COLS_DEF,
    parameter int ROWS = ROWS_DEF,
    parameter int AW   = $clog2(COLS * ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    i_byte,
    input  logic          i_byte_v,
    output logic          o_byte_done,
    output logic          o_we,
    output logic [AW-1:0] o_addr,
    output logic [7:0]    o_char,
    output logic [4:0]    o_row,
    output logic [6:0]    o_col,
    output logic          o_busy
);

    localparam logic [4:0]    c_row_max  = 5'(ROWS - 1);
    localparam logic [6:0]    c_col_max  = 7'(COLS - 1);
    localparam logic [AW-1:0] c_cols_aw  = AW'(COLS);
    localparam logic [AW-1:0] c_last     = AW'(COLS * ROWS - 1);

    state_t        r_state;
    logic          r_done, r_we, r_busy;
    logic [AW-1:0] r_addr, r_end;
    logic [7:0]    r_char;
    logic [4:0]    r_row;
    logic [6:0]    r_col;

    logic          w_accept, w_digit, w_final, w_printable;
    logic [7:0]    p0, p1, w_n, w_m1;
    logic [AW-1:0] w_row_base, w_cur_addr;
    logic [8:0]    w_row_sum, w_col_sum;
    logic [4:0]    w_h_row, w_row_up, w_row_dn, w_row_inc;
    logic [6:0]    w_h_col, w_col_lt, w_col_rt;

    // Byte classification, addressing and clamped cursor candidates
    always_comb begin
        w_accept    = i_byte_v && !r_busy && !r_done;
        w_digit     = (i_byte >= 8'h30) && (i_byte <= 8'h39);
        w_final     = (i_byte >= 8'h40) && (i_byte <= 8'h7E);
        w_printable = (i_byte >= 8'h20) && (i_byte <= 8'h7E);
        w_row_base  = AW'(r_row) * c_cols_aw;
        w_cur_addr  = w_row_base + AW'(r_col);
        w_n         = (p0 == 8'd0) ? 8'd1 : p0;
        w_row_inc   = (r_row == c_row_max) ? 5'd0 : r_row + 5'd1;
        // Absolute position: 0 treated as 1, then converted to 0-based and clamped
        w_m1        = p0 - 8'd1;
        w_h_row     = (p0 == 8'd0) ? 5'd0 : (p0 > 8'(ROWS)) ? c_row_max : w_m1[4:0];
        w_m1        = p1 - 8'd1;
        w_h_col     = (p1 == 8'd0) ? 7'd0 : (p1 > 8'(COLS)) ? c_col_max : w_m1[6:0];
        // Relative moves clamp at the screen edges
        w_row_up    = ({3'b0, r_row} <= w_n) ? 5'd0 : r_row - w_n[4:0];
        w_col_lt    = ({1'b0, r_col} <= w_n) ? 7'd0 : r_col - w_n[6:0];
        w_row_sum   = {4'b0, r_row} + {1'b0, w_n};
        w_col_sum   = {2'b0, r_col} + {1'b0, w_n};
        w_row_dn    = (w_row_sum > {4'b0, c_row_max}) ? c_row_max : w_row_sum[4:0];
        w_col_rt    = (w_col_sum > {2'b0, c_col_max}) ? c_col_max : w_col_sum[6:0];
    end

    vt_param_acc u_param_acc (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_accept && (r_state == ST_ESC) && (i_byte == c_lbrack)),
        .dig_v (w_accept && (r_state == ST_CSI) && w_digit),
        .dig   (i_byte[3:0]),
        .sep   (w_accept && (r_state == ST_CSI) && (i_byte == c_semi)),
        .p0    (p0),
        .p1    (p1)
    );

    // Decoder state machine with registered write port and handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_GROUND;
            r_done  <= 1'b0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_addr  <= '0;
            r_end   <= '0;
            r_char  <= 8'd0;
            r_row   <= 5'd0;
            r_col   <= 7'd0;
        end else begin
            r_done <= 1'b0;
            r_we   <= 1'b0;
            case (r_state)
                ST_GROUND: if (w_accept) begin
                    r_done <= 1'b1;
                    if (w_printable) begin
                        r_we   <= 1'b1;
                        r_addr <= w_cur_addr;
                        r_char <= i_byte;
                        if (r_col == c_col_max) begin
                            r_col <= 7'd0;
                            r_row <= w_row_inc;
                        end else begin
                            r_col <= r_col + 7'd1;
                        end
                    end else if (i_byte == c_cr) begin
                        r_col <= 7'd0;
                    end else if (i_byte == c_lf) begin
                        r_row <= w_row_inc;
                    end else if (i_byte == c_bs) begin
                        if (r_col != 7'd0) r_col <= r_col - 7'd1;
                    end else if (i_byte == c_esc) begin
                        r_state <= ST_ESC;
                    end
                end
                ST_ESC: if (w_accept) begin
                    r_done  <= 1'b1;
                    r_state <= (i_byte == c_lbrack) ? ST_CSI : ST_GROUND;
                end
                ST_CSI: if (w_accept) begin
                    r_done <= 1'b1;
                    if (w_digit || (i_byte == c_semi)) begin
                        r_state <= ST_CSI;
                    end else if (i_byte == c_esc) begin
                        r_state <= ST_ESC;
                    end else begin
                        r_state <= ST_GROUND;
                        if (w_final) begin
                            case (i_byte)
                                8'h48, 8'h66: begin
                                    r_row <= w_h_row;
                                    r_col <= w_h_col;
                                end
                                8'h41: r_row <= w_row_up;
                                8'h42: r_row <= w_row_dn;
                                8'h43: r_col <= w_col_rt;
                                8'h44: r_col <= w_col_lt;
                                // Erases hold the ack until the sweep finishes
                                8'h4A: if (p0 == 8'd2) begin
                                    r_done  <= 1'b0;
                                    r_state <= ST_SWEEP;
                                    r_busy  <= 1'b1;
                                    r_we    <= 1'b1;
                                    r_addr  <= '0;
                                    r_end   <= c_last;
                                    r_char  <= c_sp;
                                end
                                8'h4B: if (p0 == 8'd0) begin
                                    r_done  <= 1'b0;
                                    r_state <= ST_SWEEP;
                                    r_busy  <= 1'b1;
                                    r_we    <= 1'b1;
                                    r_addr  <= w_cur_addr;
                                    r_end   <= w_row_base + AW'(c_col_max);
                                    r_char  <= c_sp;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ST_SWEEP: begin
                    if (r_addr == r_end) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_GROUND;
                    end else begin
                        r_we   <= 1'b1;
                        r_addr <= r_addr + AW'(1);
                    end
                end
                default: r_state <= ST_GROUND;
            endcase
        end
    end

    assign o_byte_done = r_done;
    assign o_we        = r_we;
    assign o_addr      = r_addr;
    assign o_char      = r_char;
    assign o_row       = r_row;
    assign o_col       = r_col;
    assign o_busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_vt_decoder.sv
// ============================================================================
// Module      : tb_vt_decoder
// Description : Directed self-checking bench for vt_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vt_decoder;

    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    i_byte = 8'd0;
    logic          i_byte_v = 1'b0;
    logic          o_byte_done, o_we, o_busy;
    logic [AW-1:0] o_addr;
    logic [7:0]    o_char;
    logic [4:0]    o_row;
    logic [6:0]    o_col;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    logic [AW+7:0] wq[$];

    vt_decoder dut (
        .clk(clk), .rst(rst), .i_byte(i_byte), .i_byte_v(i_byte_v),
        .o_byte_done(o_byte_done), .o_we(o_we), .o_addr(o_addr), .o_char(o_char),
        .o_row(o_row), .o_col(o_col), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // Record every cell write and every done pulse
    always @(negedge clk) begin
        if (o_we) wq.push_back({o_addr, o_char});
        if (o_byte_done) done_cnt++;
    end

    // Present one byte, wait for its ack, then leave one idle cycle
    task automatic send(input logic [7:0] b, output int cyc, output int busy_cyc);
        i_byte = b; i_byte_v = 1'b1; cyc = 0; busy_cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
            if (o_busy) busy_cyc++;
        end while (!o_byte_done && cyc < 4000);
        i_byte_v = 1'b0;
        @(posedge clk); #1;
    endtask

    // Send a string of non-sweeping bytes; returns total ack cycles
    task automatic send_seq(input string s, output int total);
        int c, bc;
        total = 0;
        for (int i = 0; i < s.len(); i++) begin
            send(s[i], c, bc);
            total += c;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({o_byte_done, o_we, o_busy, o_addr, o_char, o_row, o_col} !== '0) begin
            n_bad++; $display("FAIL reset_outputs: got %h want 0",
                {o_byte_done, o_we, o_busy, o_addr, o_char, o_row, o_col});
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_print;
        int c, bc, d0;
        wq.delete(); d0 = done_cnt;
        send("H", c, bc);
        n_cmp++; if (c !== 1) begin n_bad++; $display("FAIL print_ack_h: got %0d want 1", c); end
        send("i", c, bc);
        n_cmp++; if (c !== 1) begin n_bad++; $display("FAIL print_ack_i: got %0d want 1", c); end
        n_cmp++;
        if (wq.size() !== 2 || wq[0] !== {11'd0, 8'h48} || wq[1] !== {11'd1, 8'h69}) begin
            n_bad++; $display("FAIL print_writes: got n=%0d first=%h want n=2 000/48 001/69", wq.size(),
                (wq.size() > 0) ? wq[0] : '0);
        end
        n_cmp++; if (o_col !== 7'd2) begin n_bad++; $display("FAIL print_col: got %0d want 2", o_col); end
        n_cmp++; if (done_cnt - d0 !== 2) begin n_bad++; $display("FAIL print_dones: got %0d want 2", done_cnt - d0); end
    endtask

    task automatic test_controls;
        int t, c, bc;
        // BS at col 2 twice then once more saturates at 0
        send_seq("\010\010\010", t);
        n_cmp++; if (o_col !== 7'd0) begin n_bad++; $display("FAIL bs_saturate: got %0d want 0", o_col); end
        // ESC followed by a non-'[' byte is dropped, no write, still acked
        wq.delete();
        send_seq("\033x", t);
        n_cmp++;
        if (wq.size() !== 0 || t !== 2 || o_col !== 7'd0) begin
            n_bad++; $display("FAIL esc_drop: got writes=%0d cyc=%0d col=%0d want 0 2 0", wq.size(), t, o_col);
        end
    endtask

    task automatic test_csi_pos;
        int t;
        wq.delete();
        send_seq("\033[5;10H", t);
        n_cmp++;
        if (o_row !== 5'd4 || o_col !== 7'd9 || wq.size() !== 0) begin
            n_bad++; $display("FAIL csi_h: got row=%0d col=%0d writes=%0d want 4 9 0", o_row, o_col, wq.size());
        end
        send_seq("\033[99;200H", t);
        n_cmp++;
        if (o_row !== 5'd23 || o_col !== 7'd79) begin
            n_bad++; $display("FAIL csi_h_clamp: got row=%0d col=%0d want 23 79", o_row, o_col);
        end
        send_seq("\033[3A\033[D", t);
        n_cmp++;
        if (o_row !== 5'd20 || o_col !== 7'd78) begin
            n_bad++; $display("FAIL csi_up_left: got row=%0d col=%0d want 20 78", o_row, o_col);
        end
        send_seq("\033[200C\033[300B", t);
        n_cmp++;
        if (o_row !== 5'd23 || o_col !== 7'd79) begin
            n_bad++; $display("FAIL csi_right_down: got row=%0d col=%0d want 23 79", o_row, o_col);
        end
    endtask

    task automatic test_wrap;
        int t, c, bc;
        send_seq("\033[24;80H", t);
        wq.delete();
        send("x", c, bc);
        n_cmp++;
        if (wq.size() !== 1 || wq[0] !== {11'd1919, 8'h78}) begin
            n_bad++; $display("FAIL wrap_write: got n=%0d e=%h want 1 %h", wq.size(),
                (wq.size() > 0) ? wq[0] : '0, {11'd1919, 8'h78});
        end
        n_cmp++;
        if (o_row !== 5'd0 || o_col !== 7'd0) begin
            n_bad++; $display("FAIL wrap_cursor: got row=%0d col=%0d want 0 0", o_row, o_col);
        end
    endtask

    task automatic test_erase_screen;
        int t, c, bc, d0, bad;
        send_seq("\033[6;7H\033[2", t);
        wq.delete(); d0 = done_cnt;
        send("J", c, bc);
        bad = 0;
        for (int i = 0; i < wq.size(); i++)
            if (wq[i] !== {11'(i), 8'h20}) bad++;
        n_cmp++;
        if (wq.size() !== 1920 || bad !== 0) begin
            n_bad++; $display("FAIL erase_screen_writes: got n=%0d bad=%0d want 1920 0", wq.size(), bad);
        end
        n_cmp++; if (c !== 1921) begin n_bad++; $display("FAIL erase_screen_ack: got %0d want 1921", c); end
        n_cmp++; if (bc !== 1920) begin n_bad++; $display("FAIL erase_screen_busy: got %0d want 1920", bc); end
        n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL erase_screen_dones: got %0d want 1", done_cnt - d0); end
        n_cmp++;
        if (o_row !== 5'd5 || o_col !== 7'd6) begin
            n_bad++; $display("FAIL erase_screen_cursor: got row=%0d col=%0d want 5 6", o_row, o_col);
        end
    endtask

    task automatic test_erase_line;
        int t, c, bc, bad;
        send_seq("\033[3;71H\033[", t);
        wq.delete();
        send("K", c, bc);
        bad = 0;
        for (int i = 0; i < wq.size(); i++)
            if (wq[i] !== {11'(230 + i), 8'h20}) bad++;
        n_cmp++;
        if (wq.size() !== 10 || bad !== 0 || c !== 11) begin
            n_bad++; $display("FAIL erase_line: got n=%0d bad=%0d cyc=%0d want 10 0 11", wq.size(), bad, c);
        end
        send_seq("\015\012", t);
        n_cmp++;
        if (o_row !== 5'd3 || o_col !== 7'd0) begin
            n_bad++; $display("FAIL crlf: got row=%0d col=%0d want 3 0", o_row, o_col);
        end
    endtask

    task automatic test_reset_mid_sweep;
        int t, c, bc, d0;
        send_seq("\033[2", t);
        d0 = done_cnt;
        i_byte = "J"; i_byte_v = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        n_cmp++;
        if (o_we !== 1'b1 || o_busy !== 1'b1) begin
            n_bad++; $display("FAIL sweep_running: got we=%b busy=%b want 1 1", o_we, o_busy);
        end
        rst = 1'b1; #1;
        n_cmp++;
        if ({o_byte_done, o_we, o_busy, o_addr, o_char, o_row, o_col} !== '0) begin
            n_bad++; $display("FAIL sweep_reset_outputs: got %h want 0",
                {o_byte_done, o_we, o_busy, o_addr, o_char, o_row, o_col});
        end
        i_byte_v = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (done_cnt !== d0) begin n_bad++; $display("FAIL sweep_reset_noack: got %0d want %0d", done_cnt, d0); end
        wq.delete();
        send("A", c, bc);
        n_cmp++;
        if (wq.size() !== 1 || wq[0] !== {11'd0, 8'h41} || o_col !== 7'd1) begin
            n_bad++; $display("FAIL after_reset_write: got n=%0d e=%h col=%0d want 1 %h 1", wq.size(),
                (wq.size() > 0) ? wq[0] : '0, o_col, {11'd0, 8'h41});
        end
    endtask

    initial begin
        test_reset();
        test_print();
        test_controls();
        test_csi_pos();
        test_wrap();
        test_erase_screen();
        test_erase_line();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
